logic_op_arbiter: RTL

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

---
 rtl/logic_op_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: four requesters share a single bitwise logic unit.
// A round-robin pointer selects one request at a time; the winner's opcode
// and operands are latched, evaluated one cycle later, and the result is
// held on the output until the consumer accepts it.
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [11:0]        op_bus,
  input  logic [4*WIDTH-1:0] a_bus,
  input  logic [4*WIDTH-1:0] b_bus,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic [1:0]         res_id,
  output logic               res_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NOTA = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  // Shared logic unit: purely bitwise, so the result never grows beyond WIDTH.
  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_NOTA: r = ~a;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Requester index to one-hot grant vector.
  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  state_t           state_r;
  logic [1:0]       ptr_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       id_r;
  logic [3:0]       gnt_r;
  logic             busy_r;
  logic             res_valid_r;
  logic [WIDTH-1:0] res_data_r;
  logic [1:0]       res_id_r;
  logic             res_err_r;

  logic             found_s;
  logic [1:0]       winner_s;
  logic [1:0]       cand_s;
  logic [2:0]       op_sel_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;

  // Round-robin search: first asserted request at or above ptr, wrapping 3->0.
  always_comb begin
    found_s  = 1'b0;
    winner_s = 2'd0;
    cand_s   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand_s = ptr_r + 2'(k);
      if (!found_s && req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // Route the winner's opcode and operands toward the capture registers.
  always_comb begin
    op_sel_s = 3'd0;
    a_sel_s  = {WIDTH{1'b0}};
    b_sel_s  = {WIDTH{1'b0}};
    case (winner_s)
      2'd0: begin
        op_sel_s = op_bus[2:0];
        a_sel_s  = a_bus[WIDTH*0 +: WIDTH];
        b_sel_s  = b_bus[WIDTH*0 +: WIDTH];
      end
      2'd1: begin
        op_sel_s = op_bus[5:3];
        a_sel_s  = a_bus[WIDTH*1 +: WIDTH];
        b_sel_s  = b_bus[WIDTH*1 +: WIDTH];
      end
      2'd2: begin
        op_sel_s = op_bus[8:6];
        a_sel_s  = a_bus[WIDTH*2 +: WIDTH];
        b_sel_s  = b_bus[WIDTH*2 +: WIDTH];
      end
      2'd3: begin
        op_sel_s = op_bus[11:9];
        a_sel_s  = a_bus[WIDTH*3 +: WIDTH];
        b_sel_s  = b_bus[WIDTH*3 +: WIDTH];
      end
      default: begin
        op_sel_s = 3'd0;
        a_sel_s  = {WIDTH{1'b0}};
        b_sel_s  = {WIDTH{1'b0}};
      end
    endcase
  end

  // Control FSM with all outputs registered; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 2'd0;
      op_r        <= 3'd0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      id_r        <= 2'd0;
      gnt_r       <= 4'b0000;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {WIDTH{1'b0}};
      res_id_r    <= 2'd0;
      res_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            op_r    <= op_sel_s;
            a_r     <= a_sel_s;
            b_r     <= b_sel_s;
            id_r    <= winner_s;
            gnt_r   <= to_onehot(winner_s);
            ptr_r   <= winner_s + 2'd1;
            busy_r  <= 1'b1;
            state_r <= ST_EXEC;
          end else begin
            gnt_r   <= 4'b0000;
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          // Requests arriving now are ignored; operands were latched at grant.
          res_data_r  <= logic_op(op_r, a_r, b_r);
          res_err_r   <= (op_r == OP_RSVD);
          res_id_r    <= id_r;
          res_valid_r <= 1'b1;
          gnt_r       <= 4'b0000;
          state_r     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            // Result payload stays on the bus; only valid drops.
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_HOLD;
          end
        end
        default: begin
          gnt_r       <= 4'b0000;
          busy_r      <= 1'b0;
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign res_err   = res_err_r;

endmodule
